mac_head_receiver: RTL and testbench

//  Receive-side counterpart of the MAC header transmitter. Parses a 32-bit Ethernet frame stream into
//  dst/src/type header fields and filters each frame on destination address. Realigns the payload by
//  16 bits so it starts word-aligned, and hands it to the upper layer (IP/ARP parser).

---
 rtl/mac_head_receiver_pkg.sv | 21 ++
 rtl/mac_head_receiver_realign.sv | 98 +++++++++
 rtl/mac_head_receiver.sv | 160 ++++++++++++++++
 tb/tb_mac_head_receiver.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_head_receiver_pkg.sv
// Shared definitions for the MAC receive path: byte-enable encodings,
// the broadcast address and the parser state codes.
package mac_head_receiver_pkg;

    localparam logic [1:0] BE_4B = 2'b00;
    localparam logic [1:0] BE_1B = 2'b01;
    localparam logic [1:0] BE_2B = 2'b10;
    localparam logic [1:0] BE_3B = 2'b11;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

endpackage

// File: rtl/mac_head_receiver_realign.sv
// Payload realignment: shifts the payload up by 16 bits through a residue
// register and produces the registered pl_* stream, including the flush word.
module mac_head_receiver_realign
    import mac_head_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic [1:0]  rx_be,
    input  logic        rx_eof,
    input  logic        load_res,
    input  logic        tail3,
    input  logic        shift,
    output logic [31:0] pl_data,
    output logic [1:0]  pl_be,
    output logic        pl_valid,
    output logic        pl_sof,
    output logic        pl_eof,
    output logic        flush_pend
);

    logic [15:0] res;
    logic        first;
    logic [1:0]  flush_be;

    // The flush word always comes from the residue loaded by the eof word,
    // so a new frame's header words arriving meanwhile cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res        <= '0;
            first      <= 1'b0;
            flush_be   <= BE_4B;
            flush_pend <= 1'b0;
            pl_data    <= '0;
            pl_be      <= BE_4B;
            pl_valid   <= 1'b0;
            pl_sof     <= 1'b0;
            pl_eof     <= 1'b0;
        end else begin
            pl_valid   <= 1'b0;
            pl_sof     <= 1'b0;
            pl_eof     <= 1'b0;
            pl_be      <= BE_4B;
            flush_pend <= 1'b0;

            if (flush_pend) begin
                pl_valid <= 1'b1;
                pl_data  <= {res, 16'h0000};
                pl_be    <= flush_be;
                pl_eof   <= 1'b1;
            end

            if (load_res) begin
                res   <= rx_data[15:0];
                first <= 1'b1;
            end

            if (tail3) begin
                pl_valid <= 1'b1;
                pl_sof   <= 1'b1;
                pl_eof   <= 1'b1;
                if (rx_be == BE_3B) begin
                    pl_data <= {rx_data[15:8], 24'h000000};
                    pl_be   <= BE_1B;
                end else begin
                    pl_data <= {rx_data[15:0], 16'h0000};
                    pl_be   <= BE_2B;
                end
            end

            if (shift) begin
                pl_valid <= 1'b1;
                pl_data  <= {res, rx_data[31:16]};
                pl_sof   <= first;
                first    <= 1'b0;
                res      <= rx_data[15:0];
                if (rx_eof) begin
                    case (rx_be)
                        BE_1B: begin
                            pl_be  <= BE_3B;
                            pl_eof <= 1'b1;
                        end
                        BE_2B: pl_eof <= 1'b1;
                        BE_3B: begin
                            flush_pend <= 1'b1;
                            flush_be   <= BE_1B;
                        end
                        default: begin
                            flush_pend <= 1'b1;
                            flush_be   <= BE_2B;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/mac_head_receiver.sv
// MAC receive header parser: header capture, destination filter, drop counter.
// Define MAC_RX_MCAST_EN to also accept group (multicast) destination addresses.
module mac_head_receiver
    import mac_head_receiver_pkg::*;
#(
    parameter int DROP_CNT_W = 16,
    parameter bit PROMISC    = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [47:0]           own_addr,
    input  logic [31:0]           rx_data,
    input  logic [1:0]            rx_be,
    input  logic                  rx_valid,
    input  logic                  rx_sof,
    input  logic                  rx_eof,
    output logic [47:0]           hdr_dst,
    output logic [47:0]           hdr_src,
    output logic [15:0]           hdr_type,
    output logic                  hdr_valid,
    output logic [31:0]           pl_data,
    output logic [1:0]            pl_be,
    output logic                  pl_valid,
    output logic                  pl_sof,
    output logic                  pl_eof,
    output logic                  rx_busy,
    output logic                  frm_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    rx_state_t   state, state_nxt;
    logic        err_nxt, hdr_ok_nxt, drop_nxt;
    logic        load_res, tail3, shift;
    logic        flush_pend;
    logic        addr_ok;
    logic [47:0] dst_full;

    // The low dst half is still on rx_data during the w1 decision cycle.
    assign dst_full = {hdr_dst[47:16], rx_data[31:16]};

`ifdef MAC_RX_MCAST_EN
    assign addr_ok = (dst_full == own_addr) || (dst_full == BCAST_ADDR) || PROMISC || dst_full[40];
`else
    assign addr_ok = (dst_full == own_addr) || (dst_full == BCAST_ADDR) || PROMISC;
`endif

    assign rx_busy = (state != ST_IDLE) || flush_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = 1'b0;
        hdr_ok_nxt = 1'b0;
        drop_nxt   = 1'b0;
        load_res   = 1'b0;
        tail3      = 1'b0;
        shift      = 1'b0;
        if (rx_valid) begin
            if (rx_sof) begin
                err_nxt   = (state != ST_IDLE) || rx_eof;
                state_nxt = rx_eof ? ST_IDLE : ST_HDR1;
            end else begin
                case (state)
                    ST_HDR1: begin
                        if (rx_eof) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else if (addr_ok) begin
                            state_nxt = ST_HDR2;
                        end else begin
                            drop_nxt  = 1'b1;
                            state_nxt = ST_DROP;
                        end
                    end
                    ST_HDR2: begin
                        err_nxt   = rx_eof;
                        state_nxt = rx_eof ? ST_IDLE : ST_HDR3;
                    end
                    ST_HDR3: begin
                        if (rx_eof) begin
                            state_nxt = ST_IDLE;
                            if (rx_be == BE_1B) begin
                                err_nxt = 1'b1;
                            end else begin
                                hdr_ok_nxt = 1'b1;
                                tail3      = (rx_be != BE_2B);
                            end
                        end else begin
                            hdr_ok_nxt = 1'b1;
                            load_res   = 1'b1;
                            state_nxt  = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        shift = 1'b1;
                        if (rx_eof) state_nxt = ST_IDLE;
                    end
                    ST_DROP: begin
                        if (rx_eof) state_nxt = ST_IDLE;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Header fields are captured word by word and held until the next sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_dst   <= '0;
            hdr_src   <= '0;
            hdr_type  <= '0;
            hdr_valid <= 1'b0;
            frm_err   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            hdr_valid <= hdr_ok_nxt;
            frm_err   <= err_nxt;
            if (drop_nxt && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            if (rx_valid) begin
                if (rx_sof) begin
                    hdr_dst[47:16] <= rx_data;
                end else begin
                    case (state)
                        ST_HDR1: begin
                            hdr_dst[15:0]  <= rx_data[31:16];
                            hdr_src[47:32] <= rx_data[15:0];
                        end
                        ST_HDR2: hdr_src[31:0] <= rx_data;
                        ST_HDR3: hdr_type <= rx_data[31:16];
                        default: ;
                    endcase
                end
            end
        end
    end

    mac_head_receiver_realign u_realign (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_be      (rx_be),
        .rx_eof     (rx_eof),
        .load_res   (load_res),
        .tail3      (tail3),
        .shift      (shift),
        .pl_data    (pl_data),
        .pl_be      (pl_be),
        .pl_valid   (pl_valid),
        .pl_sof     (pl_sof),
        .pl_eof     (pl_eof),
        .flush_pend (flush_pend)
    );

endmodule

// File: tb/tb_mac_head_receiver.sv
// Directed bench for mac_head_receiver: frames are built byte-wise and the
// expected realigned payload is derived from the payload bytes themselves.
module tb_mac_head_receiver;

    localparam logic [47:0] OWN   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC   = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] own_addr;
    logic [31:0] rx_data;
    logic [1:0]  rx_be;
    logic        rx_valid, rx_sof, rx_eof;

    logic [47:0] hdr_dst, hdr_src;
    logic [15:0] hdr_type;
    logic        hdr_valid;
    logic [31:0] pl_data;
    logic [1:0]  pl_be;
    logic        pl_valid, pl_sof, pl_eof, rx_busy, frm_err;
    logic [15:0] drop_cnt;

    logic [47:0] s_hdr_dst, s_hdr_src;
    logic [15:0] s_hdr_type;
    logic        s_hdr_valid;
    logic [31:0] s_pl_data;
    logic [1:0]  s_pl_be;
    logic        s_pl_valid, s_pl_sof, s_pl_eof, s_rx_busy, s_frm_err;
    logic [1:0]  s_drop_cnt;

    int n_checks = 0;
    int n_bad    = 0;
    int hdr_cnt  = 0;
    int err_cnt  = 0;
    int exp_drop = 0;

    logic [31:0] got_data[$];
    logic [1:0]  got_be[$];
    logic        got_sof[$], got_eof[$];
    logic [31:0] exp_data[$];
    logic [1:0]  exp_be[$];
    logic        exp_sof[$], exp_eof[$];

    always #5 clk = ~clk;

    mac_head_receiver dut (
        .clk(clk), .rst_n(rst_n), .own_addr(own_addr),
        .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_type(hdr_type), .hdr_valid(hdr_valid),
        .pl_data(pl_data), .pl_be(pl_be), .pl_valid(pl_valid), .pl_sof(pl_sof), .pl_eof(pl_eof),
        .rx_busy(rx_busy), .frm_err(frm_err), .drop_cnt(drop_cnt)
    );

    mac_head_receiver #(.DROP_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .own_addr(own_addr),
        .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .hdr_dst(s_hdr_dst), .hdr_src(s_hdr_src), .hdr_type(s_hdr_type), .hdr_valid(s_hdr_valid),
        .pl_data(s_pl_data), .pl_be(s_pl_be), .pl_valid(s_pl_valid), .pl_sof(s_pl_sof), .pl_eof(s_pl_eof),
        .rx_busy(s_rx_busy), .frm_err(s_frm_err), .drop_cnt(s_drop_cnt)
    );

    // Output monitor samples on the falling edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (pl_valid) begin
            got_data.push_back(pl_data);
            got_be.push_back(pl_be);
            got_sof.push_back(pl_sof);
            got_eof.push_back(pl_eof);
        end
        if (hdr_valid) hdr_cnt++;
        if (frm_err)   err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_data.delete(); got_be.delete(); got_sof.delete(); got_eof.delete();
        exp_data.delete(); exp_be.delete(); exp_sof.delete(); exp_eof.delete();
        hdr_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] be, input logic sof, input logic eof);
        rx_data  = d;
        rx_be    = be;
        rx_sof   = sof;
        rx_eof   = eof;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_be    = 2'b00;
    endtask

    // nsend=0 sends the whole frame; otherwise only the first nsend words, no eof.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ, input int n,
                              input logic [7:0] seed, input bit gappy, input int nsend);
        logic [7:0]  b [0:63];
        logic [31:0] w;
        logic [1:0]  be;
        int nbytes, nw, lim;
        nbytes = 14 + n;
        nw     = (nbytes + 3) / 4;
        lim    = (nsend == 0) ? nw : nsend;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = dst[47-8*i -: 8];
            b[6 + i] = SRC[47-8*i -: 8];
        end
        b[12] = typ[15:8];
        b[13] = typ[7:0];
        for (int i = 0; i < n; i++) b[14 + i] = seed + 8'(i);
        for (int k = 0; k < lim; k++) begin
            w  = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
            be = (k == nw - 1) ? 2'(nbytes % 4) : 2'b00;
            send_word(w, be, k == 0, k == nw - 1);
            if (gappy && k != lim - 1) idle(1);
        end
    endtask

    // Expected payload: payload bytes packed 4 per word, zero-filled at the tail.
    task automatic build_expected(input int n, input logic [7:0] seed);
        int nw;
        logic [7:0] p;
        logic [31:0] w;
        nw = (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                p = (4*k + j < n) ? seed + 8'(4*k + j) : 8'h00;
                w = {w[23:0], p};
            end
            exp_data.push_back(w);
            exp_be.push_back((k == nw - 1) ? 2'(n % 4) : 2'b00);
            exp_sof.push_back(k == 0);
            exp_eof.push_back(k == nw - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_checks++;
        if ({hdr_valid, pl_valid, frm_err, rx_busy} !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_flags got=%b want=0000", {hdr_valid, pl_valid, frm_err, rx_busy});
        end
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_drop_cnt got=%0d want=0", drop_cnt);
        end
        n_checks++;
        if ({hdr_dst, hdr_src, hdr_type, pl_data} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_data got=%h/%h/%h/%h want=0", hdr_dst, hdr_src, hdr_type, pl_data);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_unicast();
        clear_mon();
        send_frame(OWN, 16'h0800, 8, 8'h10, 1'b0, 0);
        idle(4);
        build_expected(8, 8'h10);
        n_checks++;
        if (hdr_cnt !== 1) begin n_bad++; $display("[TB] FAIL uni_hdr_valid got=%0d want=1", hdr_cnt); end
        n_checks++;
        if ({hdr_dst, hdr_src, hdr_type} !== {OWN, SRC, 16'h0800}) begin
            n_bad++;
            $display("[TB] FAIL uni_hdr got=%h/%h/%h want=%h/%h/0800", hdr_dst, hdr_src, hdr_type, OWN, SRC);
        end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_bad++;
            $display("[TB] FAIL uni_pl_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if ({got_data[i], got_be[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]}) begin
                n_bad++;
                $display("[TB] FAIL uni_pl[%0d] got=%h be=%b sof=%b eof=%b want=%h be=%b sof=%b eof=%b", i,
                         got_data[i], got_be[i], got_sof[i], got_eof[i], exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_bcast_flush();
        clear_mon();
        send_frame(BCAST, 16'h0806, 5, 8'h40, 1'b0, 0);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_busy got=%b want=1", rx_busy); end
        idle(4);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_idle got=%b want=0", rx_busy); end
        build_expected(5, 8'h40);
        n_checks++;
        if (hdr_cnt !== 1) begin n_bad++; $display("[TB] FAIL bc_hdr_valid got=%0d want=1", hdr_cnt); end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_bad++;
            $display("[TB] FAIL bc_pl_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if ({got_data[i], got_be[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]}) begin
                n_bad++;
                $display("[TB] FAIL bc_pl[%0d] got=%h be=%b sof=%b eof=%b want=%h be=%b sof=%b eof=%b", i,
                         got_data[i], got_be[i], got_sof[i], got_eof[i], exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]);
            end
        end
    endtask

    // Frames ending inside w3: header only, one 1-byte word, one 2-byte word.
    task automatic test_tail();
        clear_mon();
        send_frame(OWN, 16'h0800, 0, 8'h20, 1'b0, 0);
        idle(2);
        send_frame(OWN, 16'h0800, 1, 8'h30, 1'b0, 0);
        idle(2);
        send_frame(OWN, 16'h0800, 2, 8'h50, 1'b0, 0);
        idle(3);
        build_expected(1, 8'h30);
        build_expected(2, 8'h50);
        n_checks++;
        if (hdr_cnt !== 3 || err_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL tail_hdr got=%0d/%0d want=3/0", hdr_cnt, err_cnt);
        end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_bad++;
            $display("[TB] FAIL tail_pl_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if ({got_data[i], got_be[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]}) begin
                n_bad++;
                $display("[TB] FAIL tail_pl[%0d] got=%h be=%b sof=%b eof=%b want=%h be=%b sof=%b eof=%b", i,
                         got_data[i], got_be[i], got_sof[i], got_eof[i], exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_drop();
        clear_mon();
        for (int f = 0; f < 3; f++) begin
            send_frame(OTHER, 16'h0800, 8, 8'h70, 1'b0, 0);
            idle(1);
        end
        idle(3);
        exp_drop += 3;
        n_checks++;
        if (got_data.size() != 0 || hdr_cnt != 0) begin
            n_bad++;
            $display("[TB] FAIL drop_quiet got=%0d words/%0d hdr want=0/0", got_data.size(), hdr_cnt);
        end
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_bad++;
            $display("[TB] FAIL drop_cnt got=%0d want=%0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_mcast();
        int exp_hdr, exp_words;
        clear_mon();
        send_frame(MCAST, 16'h0800, 4, 8'h90, 1'b0, 0);
        idle(4);
`ifdef MAC_RX_MCAST_EN
        exp_hdr   = 1;
        exp_words = 1;
`else
        exp_hdr   = 0;
        exp_words = 0;
        exp_drop += 1;
`endif
        n_checks++;
        if (hdr_cnt !== exp_hdr || got_data.size() != exp_words) begin
            n_bad++;
            $display("[TB] FAIL mcast_accept got=%0d hdr/%0d words want=%0d/%0d", hdr_cnt, got_data.size(), exp_hdr, exp_words);
        end
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_bad++;
            $display("[TB] FAIL mcast_drop_cnt got=%0d want=%0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_drop_sat();
        for (int f = 0; f < 2; f++) begin
            send_frame(OTHER, 16'h0800, 4, 8'hA0, 1'b0, 0);
            idle(1);
        end
        exp_drop += 2;
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_bad++;
            $display("[TB] FAIL sat_wide_cnt got=%0d want=%0d", drop_cnt, exp_drop);
        end
        n_checks++;
        if (s_drop_cnt !== 2'd3) begin
            n_bad++;
            $display("[TB] FAIL sat_narrow_cnt got=%0d want=3", s_drop_cnt);
        end
    endtask

    task automatic test_runt();
        clear_mon();
        send_word(OWN[47:16], 2'b00, 1'b1, 1'b0);
        send_word({OWN[15:0], SRC[47:32]}, 2'b00, 1'b0, 1'b0);
        send_word(SRC[31:0], 2'b00, 1'b0, 1'b1);
        idle(2);
        n_checks++;
        if (err_cnt !== 1 || hdr_cnt !== 0 || rx_busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL runt_w2 got=err%0d hdr%0d busy%b want=err1 hdr0 busy0", err_cnt, hdr_cnt, rx_busy);
        end
        send_word(OWN[47:16], 2'b00, 1'b1, 1'b0);
        send_word({OWN[15:0], SRC[47:32]}, 2'b00, 1'b0, 1'b0);
        send_word(SRC[31:0], 2'b00, 1'b0, 1'b0);
        send_word(32'h0800_0000, 2'b01, 1'b0, 1'b1);
        idle(3);
        n_checks++;
        if (err_cnt !== 2 || hdr_cnt !== 0 || got_data.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL runt_w3 got=err%0d hdr%0d words%0d want=err2 hdr0 words0", err_cnt, hdr_cnt, got_data.size());
        end
    endtask

    task automatic test_sof_abort();
        clear_mon();
        send_frame(OWN, 16'h0800, 12, 8'h60, 1'b0, 5);
        send_frame(OWN, 16'h0800, 8, 8'h80, 1'b0, 0);
        idle(4);
        exp_data.push_back(32'h6061_6263);
        exp_be.push_back(2'b00);
        exp_sof.push_back(1'b1);
        exp_eof.push_back(1'b0);
        build_expected(8, 8'h80);
        n_checks++;
        if (err_cnt !== 1 || hdr_cnt !== 2) begin
            n_bad++;
            $display("[TB] FAIL abort_flags got=err%0d hdr%0d want=err1 hdr2", err_cnt, hdr_cnt);
        end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_bad++;
            $display("[TB] FAIL abort_pl_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if ({got_data[i], got_be[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]}) begin
                n_bad++;
                $display("[TB] FAIL abort_pl[%0d] got=%h be=%b sof=%b eof=%b want=%h be=%b sof=%b eof=%b", i,
                         got_data[i], got_be[i], got_sof[i], got_eof[i], exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]);
            end
        end
    endtask

    // Gappy input and a new sof landing in the flush cycle of the previous frame.
    task automatic test_gaps_b2b();
        clear_mon();
        send_frame(OWN, 16'h0800, 6, 8'hA0, 1'b1, 0);
        send_frame(BCAST, 16'h0800, 7, 8'hC0, 1'b1, 0);
        send_frame(OWN, 16'h0800, 10, 8'hE0, 1'b1, 0);
        idle(4);
        build_expected(6, 8'hA0);
        build_expected(7, 8'hC0);
        build_expected(10, 8'hE0);
        n_checks++;
        if (err_cnt !== 0 || hdr_cnt !== 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_flags got=err%0d hdr%0d want=err0 hdr3", err_cnt, hdr_cnt);
        end
        n_checks++;
        if (got_data.size() != exp_data.size()) begin
            n_bad++;
            $display("[TB] FAIL b2b_pl_count got=%0d want=%0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if ({got_data[i], got_be[i], got_sof[i], got_eof[i]} !== {exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]}) begin
                n_bad++;
                $display("[TB] FAIL b2b_pl[%0d] got=%h be=%b sof=%b eof=%b want=%h be=%b sof=%b eof=%b", i,
                         got_data[i], got_be[i], got_sof[i], got_eof[i], exp_data[i], exp_be[i], exp_sof[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_frame(OWN, 16'h0800, 12, 8'h11, 1'b0, 5);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pl_valid, rx_busy, hdr_valid} !== 3'b000 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL midreset got=pl%b busy%b hdr%b drop%0d want=0/0/0/0", pl_valid, rx_busy, hdr_valid, drop_cnt);
        end
        #1 rst_n = 1'b1;
        idle(2);
        clear_mon();
        send_frame(OWN, 16'h0800, 4, 8'h22, 1'b0, 0);
        idle(4);
        build_expected(4, 8'h22);
        n_checks++;
        if (got_data.size() != 1 || err_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL midreset_after got=%0d words err%0d want=1 err0", got_data.size(), err_cnt);
        end else begin
            n_checks++;
            if ({got_data[0], got_be[0], got_sof[0], got_eof[0]} !== {exp_data[0], exp_be[0], exp_sof[0], exp_eof[0]}) begin
                n_bad++;
                $display("[TB] FAIL midreset_pl got=%h be=%b want=%h be=%b", got_data[0], got_be[0], exp_data[0], exp_be[0]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        own_addr = OWN;
        rx_data  = '0;
        rx_be    = 2'b00;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        $display("[TB] mac_head_receiver directed run");
        test_reset();
        test_unicast();
        test_bcast_flush();
        test_tail();
        test_drop();
        test_mcast();
        test_drop_sat();
        test_runt();
        test_sof_abort();
        test_gaps_b2b();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
